ball_round_ctrl: RTL and testbench
==================================

Name: ball_round_ctrl

Overview:
Responder end of the round protocol driven by the top-level game FSM. It consumes the 3-bit game-state code and the who_win flag, and positions the ball at the serve point. It runs ball flight (gravity, walls, net, pikachu hits, smash) and reports the landing back as a one-cycle landed pulse plus a land side. It sits between the game FSM, the player/NPC position sources, and the display.

Parameters:
VBUF_W, 320, frame-buffer width in px
VBUF_H, 240, frame-buffer height in px
BALL_W, 30, ball width/height in px
FLOOR_Y, 220, floor line y
NET_X, 156, net left edge x
NET_W, 8, net width
NET_TOP, 150, net top y
PIKA_W, 40, pikachu box width/height
TICK_DIV, 1000000, clk cycles per physics tick
GRAVITY, 1, vy increment per tick
MAX_VY, 12, vy saturation (down)
HIT_VY, 10, upward speed after a normal hit
SMASH_VY, 4, upward speed after a player smash
SMASH_VX, -8, signed vx after a player smash
SERVE_Y, 40, serve y
PLAYER_SERVE_X, 240, serve x when who_win=0
NPC_SERVE_X, 50, serve x when who_win=1

Ports:
clk  in  1  single system clock
reset  in  1  asynchronous, active-high reset
game_state  in  3  0 start, 1 wait-for-drop, 2 in game, 3 end, 4 default/idle
who_win  in  1  0 player won last point, 1 NPC won
smash  in  1  player smash request, level
player_x, player_y  in  12  player box top-left
npc_x, npc_y  in  12  NPC box top-left
ball_x, ball_y  out  12  ball top-left
landed  out  1  one-cycle pulse on floor contact
land_side  out  1  valid with landed: 1 if ball_x+BALL_W/2 >= NET_X+NET_W/2
frame_idx  out  3  sprite rotation frame (optional feature)

Behaviour:
- Reset (async): state IDLE, ball_x=(VBUF_W-BALL_W)/2=145, ball_y=SERVE_Y, vx=vy=0, landed=0, land_side=0, frame_idx=0, tick counter=0.
- States: IDLE, SERVE_HOLD, FLIGHT, LANDED. Transitions are evaluated every cycle and registered (1-cycle latency).
- game_state 0 or 1 from any state -> SERVE_HOLD. Ball is forced to (who_win ? NPC_SERVE_X : PLAYER_SERVE_X, SERVE_Y); vx=vy=0.
- game_state 2: from SERVE_HOLD -> FLIGHT. In IDLE, stay IDLE. In LANDED, stay LANDED (no re-launch until game_state leaves 2).
- game_state 3, 4 or other: -> IDLE, position frozen.
- Tick counter runs only in FLIGHT and is cleared elsewhere. A tick fires when count==TICK_DIV-1. The first motion therefore occurs TICK_DIV cycles after FLIGHT entry.
- Per tick, in priority order, computed combinationally and registered on the tick:
  1. vy = min(vy+GRAVITY, MAX_VY).
  2. n = pos + v, using 13-bit signed arithmetic; vx/vy are 8-bit signed.
  3. Side walls: if nx<0, nx=0 and vx=-vx. If nx>VBUF_W-BALL_W, clamp and vx=-vx.
  4. Ceiling: if ny<0, ny=0 and vy=-vy.
  5. Net: if the ball box overlaps the net box (NET_X..NET_X+NET_W, NET_TOP..FLOOR_Y), nx=old x and vx=-vx.
  6. Pikachu: if vy>0 and the ball overlaps the player or NPC box (player wins a tie), vy=-HIT_VY. Then vx=clamp((ball_cx-pika_cx)>>>2, -8, +8). If the hitter is the player and smash=1, vy=-SMASH_VY and vx=SMASH_VX.
  7. Floor: if ny+BALL_W >= FLOOR_Y, ny=FLOOR_Y-BALL_W, go to LANDED, and landed=1 for exactly one cycle with land_side. Floor overrides step 6 in the same tick.
- Re-entering FLIGHT never re-pulses landed without a new contact. landed is never asserted outside the FLIGHT->LANDED edge.
- Reset mid-flight: immediate return to reset values; no landed pulse.

Optional Feature:
BALL_SPIN_EN
- Defined: on each tick in FLIGHT, frame_idx increments if vx>0 and decrements if vx<0 (mod 8). It holds when vx=0, and is cleared in SERVE_HOLD.
- Undefined: frame_idx tied to 0 and no spin logic is synthesised; the port is still present.

Decomposition:
- Shared package ball_pkg holds:
  - game-state codes (GS_START=0, GS_WAIT=1, GS_PLAY=2, GS_END=3, GS_IDLE=4);
  - the ctrl state enum;
  - coordinate width 12 and velocity width 8.
- Natural sub-module: aabb_overlap (combinational two-box overlap test), instanced three times for net, player and NPC.

Test Plan (TICK_DIV=4):
1. Assert reset mid-run -> ball=(145,40), landed=0, frame_idx=0 same cycle. Release, game_state=4 -> outputs unchanged.
2. game_state=1, who_win=1 -> next cycle ball=(50,40), held for 100 cycles.
3. game_state=1 then 2, pikachus off-screen, who_win=0 -> ball_y 41,43,46,50... per tick. Floor clamp gives ball_y=190, landed high exactly one cycle, land_side=1, then frozen in LANDED while game_state=2.
4. In flight with vy=+5, ball centred over the player box -> next tick vy=-10, vx=0. Repeat with smash=1 -> vy=-4, vx=-8.
5. Drive vx=-8 at x=4 -> next tick x=0 and vx=+8. Approach the net from the right at y=170 -> x restored and vx sign flips.
6. game_state 2->1 mid-flight -> next cycle ball at the serve point, vx=vy=0, no landed pulse.

Source files
------------

// File: rtl/ball_pkg.sv
// ball_pkg: game-state codes, controller state enum and datapath widths
// shared by the ball round controller and its helpers.
package ball_pkg;
    localparam int CW = 12;
    localparam int VW = 8;
    localparam int PW = CW + 1;
    localparam int BOX_W = CW + 2;
    localparam int HIT_VX_LIM = 8;
    localparam logic [2:0] GS_START = 3'd0;
    localparam logic [2:0] GS_WAIT = 3'd1;
    localparam logic [2:0] GS_PLAY = 3'd2;
    localparam logic [2:0] GS_END = 3'd3;
    localparam logic [2:0] GS_IDLE = 3'd4;
    typedef enum logic [1:0] {ST_IDLE, ST_SERVE_HOLD, ST_FLIGHT, ST_LANDED} ctrl_state_t;
endpackage

// File: rtl/aabb_overlap.sv
// aabb_overlap: combinational test for two axis-aligned boxes sharing any interior area.
module aabb_overlap
    import ball_pkg::*;
#(
    parameter int A_W = 30,
    parameter int A_H = 30,
    parameter int B_W = 40,
    parameter int B_H = 40
) (
    input  logic signed [BOX_W-1:0] a_x,
    input  logic signed [BOX_W-1:0] a_y,
    input  logic signed [BOX_W-1:0] b_x,
    input  logic signed [BOX_W-1:0] b_y,
    output logic                    hit
);
    assign hit = (a_x < b_x + BOX_W'(B_W)) && (b_x < a_x + BOX_W'(A_W)) &&
                 (a_y < b_y + BOX_W'(B_H)) && (b_y < a_y + BOX_W'(A_H));
endmodule

// File: rtl/ball_round_ctrl.sv
// ball_round_ctrl: serve placement, tick-driven ball flight and landing report.
// Define BALL_SPIN_EN to drive frame_idx from horizontal motion; otherwise it is tied to 0.
module ball_round_ctrl
    import ball_pkg::*;
#(
    parameter int VBUF_W = 320,
    parameter int VBUF_H = 240,
    parameter int BALL_W = 30,
    parameter int FLOOR_Y = 220,
    parameter int NET_X = 156,
    parameter int NET_W = 8,
    parameter int NET_TOP = 150,
    parameter int PIKA_W = 40,
    parameter int TICK_DIV = 1000000,
    parameter int GRAVITY = 1,
    parameter int MAX_VY = 12,
    parameter int HIT_VY = 10,
    parameter int SMASH_VY = 4,
    parameter int SMASH_VX = -8,
    parameter int SERVE_Y = 40,
    parameter int PLAYER_SERVE_X = 240,
    parameter int NPC_SERVE_X = 50
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    game_state,
    input  logic          who_win,
    input  logic          smash,
    input  logic [CW-1:0] player_x,
    input  logic [CW-1:0] player_y,
    input  logic [CW-1:0] npc_x,
    input  logic [CW-1:0] npc_y,
    output logic [CW-1:0] ball_x,
    output logic [CW-1:0] ball_y,
    output logic          landed,
    output logic          land_side,
    output logic [2:0]    frame_idx
);
    localparam int CNT_W = $clog2(TICK_DIV + 1);
    localparam int FLOOR_LINE = FLOOR_Y < VBUF_H ? FLOOR_Y : VBUF_H;
    localparam logic signed [PW-1:0] X_MAX = PW'(VBUF_W - BALL_W);

    ctrl_state_t st;
    logic signed [VW-1:0] vx, vy, vy_g, vx_w, vy_c, vx_n, vx_t, vy_t, hvx;
    logic signed [PW-1:0] cur_x, nx_r, ny_r, nx_w, ny_c, nx_n;
    logic signed [BOX_W-1:0] dcx, dsh;
    logic [CNT_W-1:0] cnt;
    logic tick, serve, net_hit, pl_hit, npc_hit, pika, floor_hit, side;

    assign tick = cnt == CNT_W'(TICK_DIV - 1);
    assign serve = game_state == GS_START || game_state == GS_WAIT;
    assign cur_x = $signed({1'b0, ball_x});

    // Gravity, integration, then wall and ceiling reflection.
    always_comb begin
        vy_g = vy >= VW'(MAX_VY - GRAVITY) ? VW'(MAX_VY) : vy + VW'(GRAVITY);
        nx_r = cur_x + $signed({{(PW-VW){vx[VW-1]}}, vx});
        ny_r = $signed({1'b0, ball_y}) + $signed({{(PW-VW){vy_g[VW-1]}}, vy_g});
        nx_w = nx_r < 0 ? '0 : (nx_r > X_MAX ? X_MAX : nx_r);
        vx_w = (nx_r < 0 || nx_r > X_MAX) ? -vx : vx;
        ny_c = ny_r < 0 ? '0 : ny_r;
        vy_c = ny_r < 0 ? -vy_g : vy_g;
    end

    aabb_overlap #(.A_W(BALL_W), .A_H(BALL_W), .B_W(NET_W), .B_H(FLOOR_Y - NET_TOP)) u_net (
        .a_x(BOX_W'(nx_w)), .a_y(BOX_W'(ny_c)),
        .b_x(BOX_W'(NET_X)), .b_y(BOX_W'(NET_TOP)), .hit(net_hit)
    );
    aabb_overlap #(.A_W(BALL_W), .A_H(BALL_W), .B_W(PIKA_W), .B_H(PIKA_W)) u_player (
        .a_x(BOX_W'(nx_n)), .a_y(BOX_W'(ny_c)),
        .b_x($signed({2'b00, player_x})), .b_y($signed({2'b00, player_y})), .hit(pl_hit)
    );
    aabb_overlap #(.A_W(BALL_W), .A_H(BALL_W), .B_W(PIKA_W), .B_H(PIKA_W)) u_npc (
        .a_x(BOX_W'(nx_n)), .a_y(BOX_W'(ny_c)),
        .b_x($signed({2'b00, npc_x})), .b_y($signed({2'b00, npc_y})), .hit(npc_hit)
    );

    // Net bounce, pikachu hit (player wins a tie) and floor contact.
    always_comb begin
        nx_n = net_hit ? cur_x : nx_w;
        vx_n = net_hit ? -vx_w : vx_w;
        pika = vy_c > 0 && (pl_hit || npc_hit);
        dcx = BOX_W'(nx_n) + BOX_W'(BALL_W / 2)
            - ($signed({2'b00, pl_hit ? player_x : npc_x}) + BOX_W'(PIKA_W / 2));
        dsh = dcx >>> 2;
        hvx = dsh > BOX_W'(HIT_VX_LIM) ? VW'(HIT_VX_LIM)
            : (dsh < -BOX_W'(HIT_VX_LIM) ? -VW'(HIT_VX_LIM) : $signed(dsh[VW-1:0]));
        vx_t = !pika ? vx_n : (pl_hit && smash ? VW'(SMASH_VX) : hvx);
        vy_t = !pika ? vy_c : (pl_hit && smash ? -VW'(SMASH_VY) : -VW'(HIT_VY));
        floor_hit = ny_c + PW'(BALL_W) >= PW'(FLOOR_LINE);
        side = BOX_W'(nx_n) + BOX_W'(BALL_W / 2) >= BOX_W'(NET_X + NET_W / 2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= ST_IDLE;
            ball_x <= CW'((VBUF_W - BALL_W) / 2);
            ball_y <= CW'(SERVE_Y);
            vx <= '0;
            vy <= '0;
            cnt <= '0;
            landed <= 1'b0;
            land_side <= 1'b0;
        end else begin
            landed <= 1'b0;
            if (serve) begin
                st <= ST_SERVE_HOLD;
                ball_x <= who_win ? CW'(NPC_SERVE_X) : CW'(PLAYER_SERVE_X);
                ball_y <= CW'(SERVE_Y);
                vx <= '0;
                vy <= '0;
                cnt <= '0;
            end else if (game_state == GS_PLAY) begin
                if (st == ST_SERVE_HOLD) begin
                    st <= ST_FLIGHT;
                    cnt <= '0;
                end else if (st == ST_FLIGHT) begin
                    cnt <= tick ? '0 : cnt + CNT_W'(1);
                    if (tick) begin
                        ball_x <= nx_n[CW-1:0];
                        ball_y <= floor_hit ? CW'(FLOOR_LINE - BALL_W) : ny_c[CW-1:0];
                        vx <= vx_t;
                        vy <= vy_t;
                        if (floor_hit) begin
                            st <= ST_LANDED;
                            landed <= 1'b1;
                            land_side <= side;
                        end
                    end
                end
            end else begin
                st <= ST_IDLE;
                cnt <= '0;
            end
        end
    end

`ifdef BALL_SPIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset || serve)
            frame_idx <= 3'd0;
        else if (game_state == GS_PLAY && st == ST_FLIGHT && tick)
            frame_idx <= frame_idx + (vx > 0 ? 3'd1 : (vx < 0 ? 3'd7 : 3'd0));
    end
`else
    assign frame_idx = 3'd0;
`endif
endmodule

// File: tb/tb_ball_round_ctrl.sv
// tb_ball_round_ctrl: directed rounds against an integer model of the ball rules.
module tb_ball_round_ctrl;
    localparam int TICK = 4;

    logic clk = 1'b0, rst = 1'b1, who_win = 1'b0, smash = 1'b0;
    logic [2:0] game_state = 3'd4;
    logic [11:0] player_x = 12'd4000, player_y = 12'd4000, npc_x = 12'd3000, npc_y = 12'd3000;
    logic [11:0] ball_x, ball_y;
    logic landed, land_side;
    logic [2:0] frame_idx;
    int total = 0, bad = 0;
    bit chk_on = 1'b0;
    int m_st, m_x, m_y, m_vx, m_vy, m_cnt, m_frame;
    bit m_land, m_side;

    ball_round_ctrl #(.TICK_DIV(TICK)) dut (
        .clk(clk), .reset(rst), .game_state(game_state), .who_win(who_win), .smash(smash),
        .player_x(player_x), .player_y(player_y), .npc_x(npc_x), .npc_y(npc_y),
        .ball_x(ball_x), .ball_y(ball_y), .landed(landed), .land_side(land_side),
        .frame_idx(frame_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit box_hit(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
        return ax < bx + bw && bx < ax + aw && ay < by + bh && by < ay + ah;
    endfunction

    // One physics tick: screen 320 wide, ball 30, net 156..164 x 150..220, floor 220.
    task automatic flight_tick();
        int nx, ny, vx, vy, d, px;
        bit ph, nh;
        vy = m_vy + 1 > 12 ? 12 : m_vy + 1;
        vx = m_vx;
        nx = m_x + vx;
        ny = m_y + vy;
        if (nx < 0 || nx > 290) begin
            nx = nx < 0 ? 0 : 290;
            vx = -vx;
        end
        if (ny < 0) begin
            ny = 0;
            vy = -vy;
        end
        if (box_hit(nx, ny, 30, 30, 156, 150, 8, 70)) begin
            nx = m_x;
            vx = -vx;
        end
        ph = vy > 0 && box_hit(nx, ny, 30, 30, int'(player_x), int'(player_y), 40, 40);
        nh = vy > 0 && box_hit(nx, ny, 30, 30, int'(npc_x), int'(npc_y), 40, 40);
        if (ph || nh) begin
            px = ph ? int'(player_x) : int'(npc_x);
            d = (nx + 15 - (px + 20)) >>> 2;
            vx = d > 8 ? 8 : (d < -8 ? -8 : d);
            vy = -10;
            if (ph && smash) begin
                vx = -8;
                vy = -4;
            end
        end
`ifdef BALL_SPIN_EN
        m_frame = (m_frame + (m_vx > 0 ? 1 : (m_vx < 0 ? 7 : 0))) % 8;
`endif
        if (ny + 30 >= 220) begin
            ny = 190;
            m_st = 3;
            m_land = 1;
            m_side = nx + 15 >= 160;
        end
        m_x = nx;
        m_y = ny;
        m_vx = vx;
        m_vy = vy;
    endtask

    // Model states: 0 idle, 1 serve hold, 2 flight, 3 landed.
    task automatic model_step();
        if (rst) begin
            m_st = 0; m_x = 145; m_y = 40; m_vx = 0; m_vy = 0;
            m_cnt = 0; m_frame = 0; m_land = 0; m_side = 0;
        end else begin
            m_land = 0;
            if (game_state <= 3'd1) begin
                m_st = 1; m_x = who_win ? 50 : 240; m_y = 40;
                m_vx = 0; m_vy = 0; m_cnt = 0; m_frame = 0;
            end else if (game_state == 3'd2) begin
                if (m_st == 1) begin
                    m_st = 2;
                    m_cnt = 0;
                end else if (m_st == 2) begin
                    if (m_cnt == TICK - 1) begin
                        m_cnt = 0;
                        flight_tick();
                    end else m_cnt++;
                end
            end else begin
                m_st = 0;
                m_cnt = 0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    task automatic compare_all();
        chk("model_ball_x", int'(ball_x), m_x);
        chk("model_ball_y", int'(ball_y), m_y);
        chk("model_landed", int'(landed), int'(m_land));
        chk("model_frame_idx", int'(frame_idx), m_frame);
        if (m_land) chk("model_land_side", int'(land_side), int'(m_side));
    endtask

    always @(negedge clk) if (chk_on) compare_all();

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic serve(input bit ww);
        game_state = 3'd1;
        who_win = ww;
        cyc(1);
    endtask

    task automatic launch();
        game_state = 3'd2;
        cyc(1);
    endtask

    task automatic wait_ticks(input int k);
        cyc(TICK * k);
    endtask

    task automatic wait_land(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cyc(1);
            seen = landed;
        end
        chk("landed_within_budget", int'(seen), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        chk("reset_x", int'(ball_x), 145);
        chk("reset_y", int'(ball_y), 40);
        chk("reset_landed", int'(landed), 0);
        rst = 1'b0;
        chk_on = 1'b1;
        cyc(2);
        // Clean fall from the player serve point.
        serve(1'b0);
        chk("serve_player_x", int'(ball_x), 240);
        chk("serve_player_y", int'(ball_y), 40);
        launch();
        wait_ticks(1); chk("fall_tick1_y", int'(ball_y), 41);
        wait_ticks(1); chk("fall_tick2_y", int'(ball_y), 43);
        wait_ticks(1); chk("fall_tick3_y", int'(ball_y), 46);
        wait_ticks(1); chk("fall_tick4_y", int'(ball_y), 50);
        wait_land(200);
        chk("floor_y", int'(ball_y), 190);
        chk("floor_side_right", int'(land_side), 1);
        cyc(1); chk("landed_one_cycle", int'(landed), 0);
        cyc(20); chk("landed_frozen_y", int'(ball_y), 190);
        // NPC serve held.
        serve(1'b1);
        chk("serve_npc_x", int'(ball_x), 50);
        chk("serve_npc_y", int'(ball_y), 40);
        cyc(100);
        chk("serve_hold_x", int'(ball_x), 50);
        chk("serve_hold_y", int'(ball_y), 40);
        // Centred player hit, then smash hit.
        player_x = 12'd235; player_y = 12'd84;
        serve(1'b0); launch();
        wait_ticks(6);
        chk("hit_x", int'(ball_x), 240);
        chk("hit_y", int'(ball_y), 46);
        cyc(40);
        player_x = 12'd4000;
        wait_land(400);
        player_x = 12'd235;
        smash = 1'b1;
        serve(1'b0); launch();
        wait_ticks(6);
        chk("smash_x", int'(ball_x), 232);
        chk("smash_y", int'(ball_y), 52);
        smash = 1'b0;
        player_x = 12'd4000;
        wait_land(400);
        // NPC hit with clamped vx, into the left wall.
        npc_x = 12'd78; npc_y = 12'd84;
        serve(1'b1); launch();
        wait_ticks(6); chk("npc_hit_x", int'(ball_x), 42);
        wait_ticks(5); chk("pre_wall_x", int'(ball_x), 2);
        wait_ticks(1); chk("wall_clamp_x", int'(ball_x), 0);
        wait_ticks(1); chk("wall_rebound_x", int'(ball_x), 8);
        npc_x = 12'd3000;
        wait_land(400);
        // Off-centre player hit drifting left into the net.
        player_x = 12'd250; player_y = 12'd84;
        serve(1'b0); launch();
        wait_ticks(6); chk("drift_x", int'(ball_x), 236);
        wait_ticks(23);
        chk("pre_net_x", int'(ball_x), 144);
        chk("pre_net_y", int'(ball_y), 112);
        wait_ticks(1);
        chk("net_restore_x", int'(ball_x), 144);
        chk("net_y", int'(ball_y), 124);
        wait_land(100);
        chk("net_land_x", int'(ball_x), 144);
        chk("net_side_left", int'(land_side), 0);
        player_x = 12'd4000;
        // Re-serve mid-flight, then end of game.
        serve(1'b0); launch();
        cyc(30);
        serve(1'b0);
        chk("reserve_x", int'(ball_x), 240);
        chk("reserve_y", int'(ball_y), 40);
        chk("reserve_no_land", int'(landed), 0);
        launch();
        cyc(10);
        game_state = 3'd3;
        cyc(5);
        // Asynchronous reset mid-flight.
        serve(1'b0); launch();
        cyc(25);
        rst = 1'b1;
        #1;
        chk("async_reset_x", int'(ball_x), 145);
        chk("async_reset_y", int'(ball_y), 40);
        chk("async_reset_landed", int'(landed), 0);
        chk("async_reset_frame", int'(frame_idx), 0);
        cyc(2);
        rst = 1'b0;
        game_state = 3'd4;
        cyc(3);
        chk("idle_after_reset_x", int'(ball_x), 145);
        chk("idle_after_reset_y", int'(ball_y), 40);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
